fetch_hazard_ctrl: RTL

Hazard and redirect controller for the fetch stage. It generates the stall, fail, newPC and JumpRegSrc inputs that the PC/NPC logic in fetch consumes. It keeps a two-slot shadow scoreboard of in-flight register writers (EX, MEM) that advances with the pipeline. From that scoreboard it resolves jr/jalr source forwarding, load-use stalls and branch-mispredict redirects.

---
 rtl/fetch_hazard_ctrl_if.sv | 36 +++
 rtl/fetch_hazard_ctrl.sv | 117 +++++++++++
 2 files changed

// File: rtl/fetch_hazard_ctrl_if.sv
// Fetch hazard/redirect bundle: ID/EX status in, stall/redirect/jr-source controls out.
// master = pipeline side driving status, slave = hazard controller.
interface fetch_hazard_ctrl_if;
    logic [31:0] if_ins;
    logic        id_valid;
    logic [4:0]  id_rs;
    logic [4:0]  id_rt;
    logic        id_use_rs;
    logic        id_use_rt;
    logic        id_wr_en;
    logic [4:0]  id_wr_reg;
    logic        id_is_load;
    logic        ex_br_valid;
    logic        ex_br_taken;
    logic        ex_br_pred;
    logic [31:0] ex_br_target;
    logic [31:0] ex_pc_plus4;
    logic        stall;
    logic        fail;
    logic [31:0] newPC;
    logic [1:0]  JumpRegSrc;

    modport master (
        output if_ins, id_valid, id_rs, id_rt, id_use_rs, id_use_rt,
               id_wr_en, id_wr_reg, id_is_load,
               ex_br_valid, ex_br_taken, ex_br_pred, ex_br_target, ex_pc_plus4,
        input  stall, fail, newPC, JumpRegSrc
    );

    modport slave (
        input  if_ins, id_valid, id_rs, id_rt, id_use_rs, id_use_rt,
               id_wr_en, id_wr_reg, id_is_load,
               ex_br_valid, ex_br_taken, ex_br_pred, ex_br_target, ex_pc_plus4,
        output stall, fail, newPC, JumpRegSrc
    );
endinterface

// File: rtl/fetch_hazard_ctrl.sv
// Fetch-stage hazard controller: shadow EX/MEM writer scoreboard, jr/jalr forwarding,
// load-use stalls and mispredict redirect. FETCH_HAZ_PERF_EN adds stall/fail counters.
module fetch_hazard_ctrl (
    input  logic                 clk,
    input  logic                 rst,
    fetch_hazard_ctrl_if.slave   hz
`ifdef FETCH_HAZ_PERF_EN
    ,
    output logic [31:0]          stall_cnt,
    output logic [15:0]          fail_cnt
`endif
);
    // Slot 0 = EX, slot 1 = MEM
    logic       slot_v_reg  [2];
    logic [4:0] slot_r_reg  [2];
    logic       slot_ld_reg [2];

    logic [1:0] slot_writer;
    logic [1:0] jr_hit;
    logic [4:0] jr_rs;
    logic       is_jr;
    logic       is_jalr;
    logic       is_jreg;
    logic       lu_stall;
    logic       jr_stall;
    logic [1:0] jr_src;
    logic       fail_raw;
    logic       stall_o;
    logic       fail_o;
    logic [31:0] new_pc_o;
    logic [1:0] src_o;

    assign jr_rs   = hz.if_ins[25:21];
    assign is_jr   = (hz.if_ins[31:26] == 6'd0) && (hz.if_ins[20:4] == 17'd0) &&
                     (hz.if_ins[5:0] == 6'b001000);
    assign is_jalr = (hz.if_ins[31:26] == 6'd0) && (hz.if_ins[20:16] == 5'd0) &&
                     (hz.if_ins[15:11] == 5'd31) && (hz.if_ins[10:6] == 5'd0) &&
                     (hz.if_ins[5:0] == 6'b001001);
    assign is_jreg = is_jr | is_jalr;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_slot
            assign slot_writer[gi] = slot_v_reg[gi] && (slot_r_reg[gi] != 5'd0);
            assign jr_hit[gi]      = slot_writer[gi] && (slot_r_reg[gi] == jr_rs);
        end
    endgenerate

    assign lu_stall = hz.id_valid && slot_writer[0] && slot_ld_reg[0] &&
                      ((hz.id_use_rs && (hz.id_rs == slot_r_reg[0])) ||
                       (hz.id_use_rt && (hz.id_rt == slot_r_reg[0])));

    // Nearest producer wins; a load still in EX has no data to forward yet
    always_comb begin
        jr_stall = 1'b0;
        jr_src   = 2'b00;
        if (is_jreg && (jr_rs != 5'd0)) begin
            if (hz.id_valid && hz.id_wr_en && (hz.id_wr_reg == jr_rs))
                jr_stall = 1'b1;
            else if (jr_hit[0] && slot_ld_reg[0])
                jr_stall = 1'b1;
            else if (jr_hit[0])
                jr_src = 2'b01;
            else if (jr_hit[1])
                jr_src = 2'b10;
        end
    end

    assign fail_raw = hz.ex_br_valid && (hz.ex_br_taken != hz.ex_br_pred);

    // The IF instruction is discarded on a redirect, so fail masks stall and jr source
    always_comb begin
        stall_o  = 1'b0;
        fail_o   = 1'b0;
        new_pc_o = 32'd0;
        src_o    = 2'b00;
        if (!rst) begin
            fail_o   = fail_raw;
            stall_o  = !fail_raw && (lu_stall || jr_stall);
            new_pc_o = (fail_raw && hz.ex_br_taken) ? hz.ex_br_target : hz.ex_pc_plus4;
            src_o    = fail_raw ? 2'b00 : jr_src;
        end
    end

    assign hz.stall      = stall_o;
    assign hz.fail       = fail_o;
    assign hz.newPC      = new_pc_o;
    assign hz.JumpRegSrc = src_o;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                slot_v_reg[i]  <= 1'b0;
                slot_r_reg[i]  <= 5'd0;
                slot_ld_reg[i] <= 1'b0;
            end
        end else begin
            slot_v_reg[1]  <= slot_v_reg[0];
            slot_r_reg[1]  <= slot_r_reg[0];
            slot_ld_reg[1] <= slot_ld_reg[0];
            slot_v_reg[0]  <= hz.id_valid && hz.id_wr_en && !stall_o && !fail_o;
            slot_r_reg[0]  <= hz.id_wr_reg;
            slot_ld_reg[0] <= hz.id_is_load;
        end
    end

`ifdef FETCH_HAZ_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= 32'd0;
            fail_cnt  <= 16'd0;
        end else begin
            stall_cnt <= stall_cnt + {31'd0, stall_o};
            fail_cnt  <= fail_cnt + {15'd0, fail_o};
        end
    end
`endif
endmodule
